alu_issue_skid: RTL and testbench

//  ID->EX issue stage for the pipelined core. Decodes opcode/funct3/funct7[5] into
//  the 4-bit ALUControl code consumed by ALU. Selects operands A/B and registers them

---
 rtl/alu_issue_skid.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue_skid.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_skid.sv
// ID->EX issue stage: ALU control decode, operand select and a 2-entry skid buffer.
// Optional feature: define ALU_ILLEGAL_TRAP_EN to add the ex_illegal output.
module alu_issue_skid #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RD_W-1:0] id_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [3:0]      ex_ALUControl,
  output logic [RD_W-1:0] ex_rd
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [RD_W-1:0] rd;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic            ill;
`endif
  } op_t;

  op_t  dec;
  op_t  main_op;
  op_t  skid_op;
  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;

  // Shared R/I funct3 mapping; SUB only exists in the register form.
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f75,
                                        input logic allow_sub);
    logic [3:0] fn;
    fn = ALU_ADD;
    case (f3)
      3'b000: fn = (allow_sub && f75) ? ALU_SUB : ALU_ADD;
      3'b001: fn = ALU_SLL;
      3'b010: fn = ALU_SLT;
      3'b011: fn = ALU_SLTU;
      3'b100: fn = ALU_XOR;
      3'b101: fn = f75 ? ALU_SRA : ALU_SRL;
      3'b110: fn = ALU_OR;
      3'b111: fn = ALU_AND;
    endcase
    return fn;
  endfunction

  always_comb begin
    dec = '0;
    case (id_opcode)
      OP_R: begin
        dec.a    = id_rs1_data;
        dec.b    = id_rs2_data;
        dec.ctrl = alu_fn(id_funct3, id_funct7_5, 1'b1);
        dec.rd   = id_rd;
`ifdef ALU_ILLEGAL_TRAP_EN
        dec.ill  = id_funct7_5 && (id_funct3 != 3'b000) && (id_funct3 != 3'b101);
`endif
      end
      OP_I: begin
        dec.a    = id_rs1_data;
        dec.b    = id_imm;
        dec.ctrl = alu_fn(id_funct3, id_funct7_5, 1'b0);
        dec.rd   = id_rd;
        if (id_funct3 == 3'b001 || id_funct3 == 3'b101)
          dec.b = {{(XLEN-5){1'b0}}, id_imm[4:0]};
`ifdef ALU_ILLEGAL_TRAP_EN
        if (id_funct3 == 3'b001)
          dec.ill = (id_imm[11:5] != 7'b0000000);
        else if (id_funct3 == 3'b101)
          dec.ill = (id_imm[11:5] != 7'b0000000) && (id_imm[11:5] != 7'b0100000);
`endif
      end
      OP_LOAD: begin
        dec.a  = id_rs1_data;
        dec.b  = id_imm;
        dec.rd = id_rd;
      end
      OP_STORE: begin
        dec.a = id_rs1_data;
        dec.b = id_imm;
      end
      OP_BRANCH: begin
        dec.a    = id_rs1_data;
        dec.b    = id_rs2_data;
        dec.ctrl = ALU_SUB;
      end
      OP_LUI: begin
        dec.b    = id_imm;
        dec.ctrl = ALU_LUI;
        dec.rd   = id_rd;
      end
      OP_AUIPC: begin
        dec.a    = id_pc;
        dec.b    = id_imm;
        dec.ctrl = ALU_AUIPC;
        dec.rd   = id_rd;
      end
      default: begin
`ifdef ALU_ILLEGAL_TRAP_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
  end

  assign id_ready = ~skid_valid;
  assign accept   = id_valid && id_ready;
  assign drain    = main_valid && ex_ready;

  // The skid slot only fills when main is held, so ID never sees ex_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_op    <= '0;
      skid_op    <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (drain) begin
        main_op    <= skid_op;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_op    <= dec;
        main_valid <= 1'b1;
      end else begin
        skid_op    <= dec;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  assign ex_valid      = main_valid;
  assign ex_A          = main_op.a;
  assign ex_B          = main_op.b;
  assign ex_ALUControl = main_op.ctrl;
  assign ex_rd         = main_op.rd;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign ex_illegal    = main_op.ill;
`endif

endmodule

// File: tb/tb_alu_issue_skid.sv
// Directed bench for alu_issue_skid: decode table, skid ordering, flush and reset.
module tb_alu_issue_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [6:0]  id_opcode = '0;
  logic [2:0]  id_funct3 = '0;
  logic        id_funct7_5 = 1'b0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic [31:0] id_imm = '0;
  logic [31:0] id_pc = '0;
  logic [4:0]  id_rd = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [3:0]  ex_ALUControl;
  logic [4:0]  ex_rd;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  int checks = 0;
  int errors = 0;
  logic [74:0] obs;
  logic [74:0] exp_v;

  alu_issue_skid #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_A(ex_A), .ex_B(ex_B), .ex_ALUControl(ex_ALUControl), .ex_rd(ex_rd)
`ifdef ALU_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {ex_valid, ex_A, ex_B, ex_ALUControl, ex_rd, id_ready};

  function automatic logic [74:0] pk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] c, input logic [4:0] rd, input logic rdy);
    return {v, a, b, c, rd, rdy};
  endfunction

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd);
    id_opcode   = opc;
    id_funct3   = f3;
    id_funct7_5 = f75;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
    id_imm      = imm;
    id_pc       = pc;
    id_rd       = rd;
    id_valid    = 1'b1;
  endtask

  // Presents one op for a single edge; returns at the following negedge with the op in main.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd);
    set_op(opc, f3, f75, rs1, rs2, imm, pc, rd);
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    exp_v = pk(1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_v);
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    checks++;
    if (ex_illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_illegal: got %b expected 0", ex_illegal);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_r_type;
    ex_ready = 1'b1;
    issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3);
    checks++;
    exp_v = pk(1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL r_add: got %h expected %h", obs, exp_v);
    end
    issue(7'b0110011, 3'b000, 1'b1, 32'd9, 32'd4, 32'h0, 32'h0, 5'd4);
    checks++;
    exp_v = pk(1'b1, 32'd9, 32'd4, 4'b0001, 5'd4, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL r_sub: got %h expected %h", obs, exp_v);
    end
    issue(7'b0110011, 3'b101, 1'b1, 32'hF0, 32'd2, 32'h0, 32'h0, 5'd8);
    checks++;
    exp_v = pk(1'b1, 32'hF0, 32'd2, 4'b1011, 5'd8, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL r_sra: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r_drain: got ex_valid=%b expected 0", ex_valid);
    end
  endtask

  task automatic test_i_type;
    issue(7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h0, 32'h405, 32'h0, 5'd2);
    checks++;
    exp_v = pk(1'b1, 32'h80000000, 32'd5, 4'b1011, 5'd2, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL i_srai: got %h expected %h", obs, exp_v);
    end
    issue(7'b0010011, 3'b000, 1'b1, 32'd10, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd6);
    checks++;
    exp_v = pk(1'b1, 32'd10, 32'hFFFFFFFF, 4'b0000, 5'd6, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL i_addi_no_sub: got %h expected %h", obs, exp_v);
    end
    issue(7'b0010011, 3'b001, 1'b0, 32'd1, 32'h0, 32'h0000003F, 32'h0, 5'd7);
    checks++;
    exp_v = pk(1'b1, 32'd1, 32'h1F, 4'b0111, 5'd7, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL i_slli_shamt: got %h expected %h", obs, exp_v);
    end
    issue(7'b0010011, 3'b011, 1'b0, 32'd3, 32'h0, 32'h123, 32'h0, 5'd9);
    checks++;
    exp_v = pk(1'b1, 32'd3, 32'h123, 4'b0110, 5'd9, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL i_sltiu: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_upper_mem_branch;
    issue(7'b0010111, 3'b000, 1'b0, 32'hAA, 32'hBB, 32'h3000, 32'h100, 5'd1);
    checks++;
    exp_v = pk(1'b1, 32'h100, 32'h3000, 4'b1000, 5'd1, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL auipc: got %h expected %h", obs, exp_v);
    end
    issue(7'b0110111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h12345000, 32'h200, 5'd10);
    checks++;
    exp_v = pk(1'b1, 32'h0, 32'h12345000, 4'b1001, 5'd10, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL lui: got %h expected %h", obs, exp_v);
    end
    issue(7'b0100011, 3'b010, 1'b0, 32'h20, 32'h99, 32'h8, 32'h0, 5'd7);
    checks++;
    exp_v = pk(1'b1, 32'h20, 32'h8, 4'b0000, 5'd0, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL store: got %h expected %h", obs, exp_v);
    end
    issue(7'b1100011, 3'b000, 1'b0, 32'd3, 32'd4, 32'h10, 32'h0, 5'd9);
    checks++;
    exp_v = pk(1'b1, 32'd3, 32'd4, 4'b0001, 5'd0, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL branch: got %h expected %h", obs, exp_v);
    end
    issue(7'b0000011, 3'b010, 1'b0, 32'h40, 32'h1, 32'hFFFFFFFC, 32'h0, 5'd6);
    checks++;
    exp_v = pk(1'b1, 32'h40, 32'hFFFFFFFC, 4'b0000, 5'd6, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL load: got %h expected %h", obs, exp_v);
    end
    issue(7'b1111111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd5);
    checks++;
    exp_v = pk(1'b1, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL nop_opcode: got %h expected %h", obs, exp_v);
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    checks++;
    if (ex_illegal !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nop_illegal: got %b expected 1", ex_illegal);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    ex_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h1, 32'h0, 32'h0, 5'd1);
    @(negedge clk);
    checks++;
    exp_v = pk(1'b1, 32'h11, 32'h1, 4'b0000, 5'd1, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected %h", obs, exp_v);
    end
    set_op(7'b0110011, 3'b000, 1'b0, 32'h22, 32'h2, 32'h0, 32'h0, 5'd2);
    @(negedge clk);
    checks++;
    exp_v = pk(1'b1, 32'h11, 32'h1, 4'b0000, 5'd1, 1'b0);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL b2b_skid_full: got %h expected %h", obs, exp_v);
    end
    set_op(7'b0110011, 3'b000, 1'b1, 32'h33, 32'h3, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL b2b_stall_stable: got %h expected %h", obs, exp_v);
    end
    ex_ready = 1'b1;
    @(negedge clk);
    checks++;
    exp_v = pk(1'b1, 32'h22, 32'h2, 4'b0000, 5'd2, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    id_valid = 1'b0;
    checks++;
    exp_v = pk(1'b1, 32'h33, 32'h3, 4'b0001, 5'd3, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL b2b_third: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_no_dup: got ex_valid=%b expected 0", ex_valid);
    end
  endtask

  task automatic test_flush;
    ex_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'h44, 32'h4, 32'h0, 32'h0, 5'd4);
    @(negedge clk);
    set_op(7'b0110011, 3'b000, 1'b0, 32'h55, 32'h5, 32'h0, 32'h0, 5'd5);
    @(negedge clk);
    set_op(7'b0110011, 3'b000, 1'b0, 32'h66, 32'h6, 32'h0, 32'h0, 5'd6);
    flush = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    checks++;
    if ({ex_valid, id_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush_full: got valid/ready=%b%b expected 01", ex_valid, id_ready);
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_op_lost: got ex_valid=%b expected 0", ex_valid);
    end
    set_op(7'b0110011, 3'b000, 1'b0, 32'h77, 32'h7, 32'h0, 32'h0, 5'd7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    checks++;
    if ({ex_valid, id_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush_accept_ignored: got valid/ready=%b%b expected 01", ex_valid, id_ready);
    end
  endtask

  task automatic test_reset_midstream;
    ex_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'h88, 32'h8, 32'h0, 32'h0, 5'd8);
    @(negedge clk);
    set_op(7'b0110011, 3'b000, 1'b1, 32'h99, 32'h9, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    exp_v = pk(1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b1);
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    id_valid = 1'b0;
    ex_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_survivor: got ex_valid=%b expected 0", ex_valid);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_upper_mem_branch();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
